// File: rtl/montgomery_param.sv
// Montgomery modular multiplier: result = a*b*2^-WIDTH mod m, K radix-2 steps per clock.
// Operands are captured on an accepted start; an even modulus reports err instead of iterating.
module montgomery_param #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned K     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int unsigned Iters = WIDTH / K;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

  if (K != 1 && K != 2) begin : g_bad_k
    $error("montgomery_param: K must be 1 or 2");
  end
  if (WIDTH < 4 || (WIDTH % K) != 0) begin : g_bad_width
    $error("montgomery_param: WIDTH must be >= 4 and a multiple of K");
  end

  // StErr adds the one-cycle latency of the even-modulus report without raising busy.
  typedef enum logic [1:0] {StIdle, StIter, StSub, StErr} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH+1:0] c_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH+1:0] c_next;
  logic [WIDTH+1:0] diff;

  // K chained steps; the parity test sees the accumulator after the B add.
  always_comb begin
    c_next = c_q;
    for (int j = 0; j < int'(K); j++) begin
      if (a_q[j]) c_next = c_next + {2'b00, b_q};
      if (c_next[0]) c_next = c_next + {2'b00, m_q};
      c_next = c_next >> 1;
    end
  end

  // C < 2M, so the sign bit of C - M decides the final subtraction.
  assign diff = c_q - {2'b00, m_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (in_m[0]) begin
              a_q     <= in_a;
              b_q     <= in_b;
              m_q     <= in_m;
              c_q     <= '0;
              cnt_q   <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              state_q <= StIter;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StIter: begin
          c_q   <= c_next;
          a_q   <= a_q >> K;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_q <= StSub;
        end
        StSub: begin
          result  <= diff[WIDTH+1] ? c_q[WIDTH-1:0] : diff[WIDTH-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StErr: begin
          result  <= '0;
          err     <= 1'b1;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_param.sv
// Bench for montgomery_param: 8-bit K=2, 8-bit K=1 and 1024-bit K=2 instances,
// table vectors, corner sequences and random operands against an arithmetic model.
module tb_montgomery_param;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [2:0]    start_v;
  logic [1023:0] a_in, b_in, m_in;
  logic [7:0]    r0, r1;
  logic [1023:0] r2;
  logic [2:0]    done_v, busy_v, err_v;

  int            sel;
  logic [1023:0] res_s;
  logic          done_s, busy_s, err_s;

  int nvec = 0;
  int nmis = 0;

  montgomery_param #(.WIDTH(8), .K(2)) u_w8k2 (
    .clk(clk), .resetn(resetn), .start(start_v[0]),
    .in_a(a_in[7:0]), .in_b(b_in[7:0]), .in_m(m_in[7:0]),
    .result(r0), .done(done_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  montgomery_param #(.WIDTH(8), .K(1)) u_w8k1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]),
    .in_a(a_in[7:0]), .in_b(b_in[7:0]), .in_m(m_in[7:0]),
    .result(r1), .done(done_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  montgomery_param #(.WIDTH(1024), .K(2)) u_w1024k2 (
    .clk(clk), .resetn(resetn), .start(start_v[2]),
    .in_a(a_in), .in_b(b_in), .in_m(m_in),
    .result(r2), .done(done_v[2]), .busy(busy_v[2]), .err(err_v[2])
  );

  always_comb begin
    res_s  = r2;
    done_s = done_v[2];
    busy_s = busy_v[2];
    err_s  = err_v[2];
    if (sel == 0) begin
      res_s  = {1016'b0, r0};
      done_s = done_v[0];
      busy_s = busy_v[0];
      err_s  = err_v[0];
    end else if (sel == 1) begin
      res_s  = {1016'b0, r1};
      done_s = done_v[1];
      busy_s = busy_v[1];
      err_s  = err_v[1];
    end
  end

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (low 512 bits)", name, act[511:0], exp[511:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // a*b*2^-w mod m: reduce the product, then halve w times modulo the odd m.
  function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m, input int w);
    logic [2047:0] p;
    logic [1024:0] x;
    p = {1024'b0, a} * {1024'b0, b};
    p = p % {1024'b0, m};
    x = {1'b0, p[1023:0]};
    for (int i = 0; i < w; i++) begin
      if (x[0]) x = x + {1'b0, m};
      x = x >> 1;
    end
    return x[1023:0];
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] x;
    for (int i = 0; i < 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic int lat_exp(input int s);
    return (s == 2) ? 513 : (s == 1) ? 9 : 5;
  endfunction

  // Pulse start on DUT s; with b2b the caller is already just past a done edge.
  task automatic run_op(input int s, input logic [1023:0] a, input logic [1023:0] b,
                        input logic [1023:0] m, input bit b2b, output logic [1023:0] r,
                        output logic e, output int lat, output int bcnt);
    sel = s;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    a_in = a;
    b_in = b;
    m_in = m;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v = '0;
    lat  = 0;
    bcnt = busy_s ? 1 : 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_s) bcnt++;
    end while (!done_s && lat < 1100);
    r = res_s;
    e = err_s;
  endtask

  typedef struct {
    int         s;
    logic [7:0] a, b, m, r;
    logic       e;
  } vec_t;

  vec_t          tbl[10];
  logic [1023:0] r, a, b, m;
  logic          e;
  int            lat, bcnt, ndone;

  initial begin
    tbl[0] = '{0, 8'd5,   8'd7,   8'd13,  8'd1,   1'b0};
    tbl[1] = '{1, 8'd12,  8'd12,  8'd13,  8'd3,   1'b0};
    tbl[2] = '{1, 8'd0,   8'd12,  8'd13,  8'd0,   1'b0};
    tbl[3] = '{0, 8'd3,   8'd4,   8'd11,  8'd4,   1'b0};
    tbl[4] = '{1, 8'd100, 8'd200, 8'd255, 8'd110, 1'b0};
    tbl[5] = '{0, 8'd12,  8'd12,  8'd13,  8'd3,   1'b0};
    tbl[6] = '{0, 8'd9,   8'd3,   8'd12,  8'd0,   1'b1};
    tbl[7] = '{0, 8'd5,   8'd7,   8'd13,  8'd1,   1'b0};
    tbl[8] = '{1, 8'd100, 8'd200, 8'd255, 8'd110, 1'b0};
    tbl[9] = '{1, 8'd1,   8'd1,   8'd4,   8'd0,   1'b1};

    sel     = 0;
    start_v = '0;
    a_in    = '0;
    b_in    = '0;
    m_in    = '0;
    resetn  = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_result", res_s, '0);
      check_int("reset_done", int'(done_s), 0);
      check_int("reset_busy", int'(busy_s), 0);
      check_int("reset_err", int'(err_s), 0);
    end
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].s, {1016'b0, tbl[i].a}, {1016'b0, tbl[i].b}, {1016'b0, tbl[i].m}, 1'b0,
             r, e, lat, bcnt);
      check("tbl_result", r, {1016'b0, tbl[i].r});
      check_int("tbl_err", int'(e), int'(tbl[i].e));
      check_int("tbl_latency", lat, tbl[i].e ? 1 : lat_exp(tbl[i].s));
      check_int("tbl_busy_cycles", bcnt, tbl[i].e ? 0 : lat_exp(tbl[i].s));
    end

    // Operands and start churn while busy; the captured 5,7,13 must still win.
    sel = 0;
    @(posedge clk);
    #1;
    a_in = 1024'd5;
    b_in = 1024'd7;
    m_in = 1024'd13;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    lat   = 0;
    ndone = 0;
    repeat (8) begin
      a_in[7:0] = 8'($urandom);
      b_in[7:0] = 8'($urandom);
      m_in[7:0] = 8'($urandom);
      start_v[0] = (lat == 1);
      @(posedge clk);
      #1;
      lat++;
      if (done_s) begin
        ndone++;
        if (ndone == 1) begin
          check_int("churn_latency", lat, 5);
          check("churn_result", res_s, 1024'd1);
        end
      end
    end
    start_v = '0;
    check_int("churn_done_count", ndone, 1);

    // Reset in the second ITER cycle aborts silently.
    @(posedge clk);
    #1;
    a_in = 1024'd5;
    b_in = 1024'd7;
    m_in = 1024'd13;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    check_int("rst_busy_before", int'(busy_s), 1);
    resetn = 1'b0;
    #1;
    check("rst_result", res_s, '0);
    check_int("rst_done", int'(done_s), 0);
    check_int("rst_busy", int'(busy_s), 0);
    check_int("rst_err", int'(err_s), 0);
    @(negedge clk);
    resetn = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_s) ndone++;
    end
    check_int("rst_no_done", ndone, 0);
    run_op(0, 1024'd5, 1024'd7, 1024'd13, 1'b0, r, e, lat, bcnt);
    check("rst_after_result", r, 1024'd1);
    check_int("rst_after_latency", lat, 5);

    // Random 8-bit operands on both K variants.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        m = '0;
        a = '0;
        b = '0;
        m[7:0] = 8'(2 * $urandom_range(1, 127) + 1);
        a[7:0] = 8'($urandom_range(0, int'(m[7:0]) - 1));
        b[7:0] = 8'($urandom_range(0, int'(m[7:0]) - 1));
        run_op(s, a, b, m, 1'b0, r, e, lat, bcnt);
        check("rand8_result", r, mont_ref(a, b, m, 8));
        check_int("rand8_latency", lat, lat_exp(s));
      end
    end

    // Random 1024-bit operands, each start issued on the previous done cycle.
    for (int i = 0; i < 100; i++) begin
      m = rand_wide();
      m[0] = 1'b1;
      m[1023] = 1'b1;
      a = rand_wide() % m;
      b = rand_wide() % m;
      run_op(2, a, b, m, i > 0, r, e, lat, bcnt);
      check("wide_result", r, mont_ref(a, b, m, 1024));
      check_int("wide_latency", lat, 513);
      if (i % 25 == 0) check_int("wide_err", int'(e), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
